// File: rtl/serial_fa_seq.sv
// serial_fa_seq: bit-serial ripple adder, one bit per clock LSB-first, with valid/ready handshakes.
module serial_fa_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic           carry, accept, last, s, c_nxt;
  logic [CW-1:0]  cnt;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    in_ready  = state == IDLE;
    busy      = state == RUN;
    out_valid = state == DONE;
    accept    = in_ready && in_valid;
    last      = cnt == CW'(WIDTH - 1);
    s         = a_sh[0] ^ b_sh[0] ^ carry;
    c_nxt     = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                                (out_ready ? IDLE : DONE);
  end
  // sum fills from the MSB so that after WIDTH shifts bit 0 sits at the LSB
  always_ff @(posedge clk)
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (busy) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= c_nxt;
      cnt   <= cnt + CW'(1);
      sum   <= (sum >> 1) | (WIDTH'(s) << (WIDTH - 1));
      if (last) cout <= c_nxt;
    end
endmodule

// File: tb/tb_serial_fa_seq.sv
// tb_serial_fa_seq: vector table plus scoreboard checks for 8-bit and 1-bit serial adders.
module tb_serial_fa_seq;
  logic clk = 0, rst = 1;
  logic in_valid8 = 0, cin8 = 0, out_ready8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic in_ready8, out_valid8, cout8, busy8;
  logic [7:0] sum8;
  logic in_valid1 = 0, a1 = 0, b1 = 0, cin1 = 0, out_ready1 = 0;
  logic in_ready1, out_valid1, cout1, busy1, sum1;
  int n_chk = 0, n_fail = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  typedef struct {
    logic [7:0] a, b;
    logic cin;
    logic [7:0] sum;
    logic cout;
    int hold;
  } vec_t;
  vec_t tbl[6];
  always #5 clk = ~clk;
  serial_fa_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8), .busy(busy8)
  );
  serial_fa_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1), .busy(busy1)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic pop8();
    logic [8:0] e;
    if (q8.size() == 0) chk("q8_empty", 1, 0);
    else begin
      e = q8.pop_front();
      chk("result8", {cout8, sum8}, e);
    end
  endtask
  task automatic add8(input logic [7:0] x, input logic [7:0] y, input logic c,
                      input logic [7:0] es, input logic ec, input int hold);
    int lat;
    @(negedge clk);
    chk("in_ready8_idle", in_ready8, 1);
    in_valid8 = 1; a8 = x; b8 = y; cin8 = c;
    q8.push_back({ec, es});
    @(negedge clk);
    lat = 0;
    in_valid8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    chk("busy8", busy8, 1);
    while (!out_valid8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency8", lat, 8);
    for (int i = 0; i < hold; i++) begin
      in_valid8 = 1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", out_valid8, 1);
      chk("hold_in_ready", in_ready8, 0);
      chk("hold_result", {cout8, sum8}, {ec, es});
    end
    in_valid8 = 0;
    pop8();
    out_ready8 = 1;
    @(negedge clk);
    out_ready8 = 0;
    chk("idle_after_hs", {out_valid8, in_ready8}, 2'b01);
    chk("retain_after_hs", {cout8, sum8}, {ec, es});
  endtask
  initial begin
    int lat, seen, last_acc, n_acc;
    logic [1:0] e1;
    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0};
    tbl[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1};
    tbl[5] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1, 5};
    repeat (3) @(negedge clk);
    chk("rst_state8", {in_ready8, out_valid8, busy8, cout8, sum8}, {3'b100, 9'h000});
    chk("rst_state1", {in_ready1, out_valid1, busy1, cout1, sum1}, 5'b10000);
    rst = 0;
    foreach (tbl[i]) add8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].hold);
    // reset on the 4th RUN edge discards the partial result
    @(negedge clk);
    in_valid8 = 1; a8 = 8'h77; b8 = 8'h99; cin8 = 1;
    @(negedge clk);
    in_valid8 = 0;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", busy8, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_run_state", {in_ready8, out_valid8, busy8}, 3'b100);
    chk("rst_run_sum", {cout8, sum8}, 9'h000);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid8) seen++;
    end
    chk("no_valid_after_rst", seen, 0);
    add8(8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0, 0);
    // reset while a result waits in DONE
    @(negedge clk);
    in_valid8 = 1; a8 = 8'h01; b8 = 8'h02; cin8 = 0;
    @(negedge clk);
    in_valid8 = 0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("done_reached", out_valid8, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_done_state", {in_ready8, out_valid8, busy8, cout8, sum8}, {3'b100, 9'h000});
    // back-to-back with in_valid and out_ready held high
    out_ready8 = 1; in_valid8 = 1;
    last_acc = -1; n_acc = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      if (in_ready8) begin
        q8.push_back({1'b0, a8} + {1'b0, b8} + {8'h00, cin8});
        if (last_acc >= 0) chk("bb_interval", cyc - last_acc, 10);
        last_acc = cyc;
        n_acc++;
      end
      if (out_valid8) pop8();
      @(negedge clk);
    end
    in_valid8 = 0; out_ready8 = 0;
    chk("bb_accepts", n_acc, 6);
    chk("bb_drained", q8.size(), 0);
    // 1-bit instance: full-adder truth table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("in_ready1", in_ready1, 1);
      {a1, b1, cin1} = 3'(i);
      q1.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, cin1});
      in_valid1 = 1;
      @(negedge clk);
      in_valid1 = 0;
      chk("run1", {busy1, out_valid1}, 2'b10);
      @(negedge clk);
      chk("valid1", out_valid1, 1);
      e1 = q1.pop_front();
      chk("result1", {cout1, sum1}, e1);
      out_ready1 = 1;
      @(negedge clk);
      out_ready1 = 0;
      chk("idle1", {in_ready1, out_valid1}, 2'b10);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
